// File: rtl/kf8253_counter.sv
`default_nettype none
// ============================================================================
//  Module      : kf8253_counter
//  Description : One counter channel of an 8253-style programmable interval
//                timer. Supports mode 0 (interrupt on terminal count) and
//                mode 2 (rate generator) with binary counting, an RW-selected
//                byte interface for count writes and reads, and a 16-bit
//                count latch. All state updates on the falling edge of clock.
//  Ports       : clock             - system clock (falling-edge active)
//                reset             - asynchronous, active-high reset
//                internal_data_bus - latched CPU write data
//                write_control     - control word strobe for this counter
//                write_counter     - count byte strobe for this counter
//                read_counter      - high while the CPU reads this counter
//                counter_clock     - asynchronous CLKn pin
//                counter_gate      - asynchronous GATEn pin
//                counter_out       - OUTn pin
//                read_data         - byte presented for the current CPU read
//  Revision    : 1.0 - initial release
// ============================================================================
module kf8253_counter (
   input  logic       clock,
   input  logic       reset,
   input  logic [7:0] internal_data_bus,
   input  logic       write_control,
   input  logic       write_counter,
   input  logic       read_counter,
   input  logic       counter_clock,
   input  logic       counter_gate,
   output logic       counter_out,
   output logic [7:0] read_data
);

   localparam logic [1:0] c_RW_LATCH = 2'b00;
   localparam logic [1:0] c_RW_LSB   = 2'b01;
   localparam logic [1:0] c_RW_MSB   = 2'b10;
   localparam logic [1:0] c_RW_BOTH  = 2'b11;

   typedef enum logic [0:0] {
      c_MODE0 = 1'b0,
      c_MODE2 = 1'b1
   } mode_t;

   // Configuration
   logic [1:0]  r_rw;
   mode_t       r_mode;
   logic        r_bcd;

   // Count datapath
   logic [15:0] r_initial;
   logic [15:0] r_count;
   logic [15:0] r_latch;
   logic [7:0]  r_lsb_buf;
   logic        r_latched;
   logic        r_wr_msb;
   logic        r_rd_msb;
   logic        r_counting;
   logic        r_load_pend;
   logic        r_reload_req;
   logic        r_out;

   // Synchronisers and edge detectors
   logic [1:0]  r_clk_sync;
   logic        r_clk_prev;
   logic [1:0]  r_gate_sync;
   logic        r_gate_prev;
   logic        r_read_prev;

   logic        w_count_event;
   logic        w_gate_rise;
   logic        w_gate;
   logic        w_read_fall;
   logic [15:0] w_count_dec;
   logic [15:0] w_rd_src;
   mode_t       w_ctrl_mode;
   logic [2:0]  w_unused_bits;

   assign w_count_event = r_clk_sync[1] & ~r_clk_prev;
   assign w_gate        = r_gate_sync[1];
   assign w_gate_rise   = r_gate_sync[1] & ~r_gate_prev;
   assign w_read_fall   = r_read_prev & ~read_counter;
   assign w_count_dec   = r_count - 16'd1;
   assign w_ctrl_mode   = (internal_data_bus[3:1] == 3'b000) ? c_MODE0 : c_MODE2;
   // BCD is recorded but counting is always binary; the select bits are
   // decoded upstream by the control logic.
   assign w_unused_bits = {internal_data_bus[7:6], r_bcd};

   assign counter_out = r_out;
   assign w_rd_src    = r_latched ? r_latch : r_count;

   always_comb begin
      read_data = w_rd_src[7:0];
      case (r_rw)
         c_RW_MSB:  read_data = w_rd_src[15:8];
         c_RW_BOTH: read_data = r_rd_msb ? w_rd_src[15:8] : w_rd_src[7:0];
         default:   read_data = w_rd_src[7:0];
      endcase
   end

   always_ff @(negedge clock or posedge reset) begin
      if (reset) begin
         r_rw         <= c_RW_BOTH;
         r_mode       <= c_MODE0;
         r_bcd        <= 1'b0;
         r_initial    <= 16'h0000;
         r_count      <= 16'h0000;
         r_latch      <= 16'h0000;
         r_lsb_buf    <= 8'h00;
         r_latched    <= 1'b0;
         r_wr_msb     <= 1'b0;
         r_rd_msb     <= 1'b0;
         r_counting   <= 1'b0;
         r_load_pend  <= 1'b0;
         r_reload_req <= 1'b0;
         r_out        <= 1'b0;
         r_clk_sync   <= 2'b00;
         r_clk_prev   <= 1'b0;
         r_gate_sync  <= 2'b00;
         r_gate_prev  <= 1'b0;
         r_read_prev  <= 1'b0;
      end else begin
         r_clk_sync  <= {r_clk_sync[0], counter_clock};
         r_clk_prev  <= r_clk_sync[1];
         r_gate_sync <= {r_gate_sync[0], counter_gate};
         r_gate_prev <= r_gate_sync[1];
         r_read_prev <= read_counter;

         // Read pointer / latch release; a control write below overrides.
         if (w_read_fall) begin
            if (r_rw == c_RW_BOTH)
               r_rd_msb <= ~r_rd_msb;
            if (r_latched && ((r_rw != c_RW_BOTH) || r_rd_msb))
               r_latched <= 1'b0;
         end

         if (write_control) begin
            // Control write wins over a coincident count event, which is lost.
            if (internal_data_bus[5:4] == c_RW_LATCH) begin
               if (!r_latched) begin
                  r_latch   <= r_count;
                  r_latched <= 1'b1;
               end
            end else begin
               r_rw         <= internal_data_bus[5:4];
               r_mode       <= w_ctrl_mode;
               r_bcd        <= internal_data_bus[0];
               r_wr_msb     <= 1'b0;
               r_rd_msb     <= 1'b0;
               r_latched    <= 1'b0;
               r_counting   <= 1'b0;
               r_load_pend  <= 1'b0;
               r_reload_req <= 1'b0;
               r_out        <= (w_ctrl_mode == c_MODE2);
            end
         end else begin
            if (write_counter) begin
               case (r_rw)
                  c_RW_LSB: begin
                     r_initial   <= {8'h00, internal_data_bus};
                     r_load_pend <= 1'b1;
                  end
                  c_RW_MSB: begin
                     r_initial   <= {internal_data_bus, 8'h00};
                     r_load_pend <= 1'b1;
                  end
                  default: begin
                     // LSB is held aside so a mode 2 reload between the two
                     // bytes still uses the previous complete value.
                     if (!r_wr_msb) begin
                        r_lsb_buf <= internal_data_bus;
                        r_wr_msb  <= 1'b1;
                        if (r_mode == c_MODE0)
                           r_counting <= 1'b0;
                     end else begin
                        r_initial   <= {internal_data_bus, r_lsb_buf};
                        r_wr_msb    <= 1'b0;
                        r_load_pend <= 1'b1;
                     end
                  end
               endcase
               if (r_mode == c_MODE0)
                  r_out <= 1'b0;
            end else if (w_count_event) begin
               if (!r_counting || (r_mode == c_MODE0)) begin
                  // First event after a load (or any mode 0 reload) copies
                  // the initial value without decrementing.
                  if (r_load_pend) begin
                     r_count      <= r_initial;
                     r_counting   <= 1'b1;
                     r_load_pend  <= 1'b0;
                     r_reload_req <= 1'b0;
                  end else if (r_counting && w_gate) begin
                     r_count <= w_count_dec;
                     if (w_count_dec == 16'h0000)
                        r_out <= 1'b1;
                  end
               end else if (w_gate) begin
                  // Mode 2: a pending count write waits for the reload point.
                  if ((r_count == 16'h0001) || r_reload_req || w_gate_rise) begin
                     r_count      <= r_initial;
                     r_out        <= 1'b1;
                     r_load_pend  <= 1'b0;
                     r_reload_req <= 1'b0;
                  end else begin
                     r_count <= w_count_dec;
                     if (w_count_dec == 16'h0001)
                        r_out <= 1'b0;
                  end
               end
            end

            if ((r_mode == c_MODE2) && r_counting && w_gate_rise && !w_count_event)
               r_reload_req <= 1'b1;

            if ((r_mode == c_MODE2) && !w_gate)
               r_out <= 1'b1;
         end
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_kf8253_counter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_kf8253_counter
//  Description : Directed self-checking bench for kf8253_counter. Inputs are
//                driven and outputs sampled on the rising clock edge, away
//                from the falling edge the design updates on.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_kf8253_counter;

   logic       clock;
   logic       reset;
   logic [7:0] internal_data_bus;
   logic       write_control;
   logic       write_counter;
   logic       read_counter;
   logic       counter_clock;
   logic       counter_gate;
   logic       counter_out;
   logic [7:0] read_data;

   int n_vec;
   int n_miss;

   kf8253_counter dut (
      .clock             (clock),
      .reset             (reset),
      .internal_data_bus (internal_data_bus),
      .write_control     (write_control),
      .write_counter     (write_counter),
      .read_counter      (read_counter),
      .counter_clock     (counter_clock),
      .counter_gate      (counter_gate),
      .counter_out       (counter_out),
      .read_data         (read_data)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic check_value(input string tag, input logic [15:0] got, input logic [15:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_miss++;
         $display("FAIL %s: got %h, expected %h", tag, got, exp);
      end
   endtask

   task automatic cpu_ctrl(input logic [7:0] v);
      internal_data_bus = v;
      write_control     = 1'b1;
      @(posedge clock);
      write_control     = 1'b0;
      @(posedge clock);
   endtask

   task automatic cpu_write(input logic [7:0] v);
      internal_data_bus = v;
      write_counter     = 1'b1;
      @(posedge clock);
      write_counter     = 1'b0;
      @(posedge clock);
   endtask

   task automatic cpu_read(output logic [7:0] d);
      read_counter = 1'b1;
      @(posedge clock);
      d = read_data;
      read_counter = 1'b0;
      repeat (2) @(posedge clock);
   endtask

   // One full CLKn period; the count event lands within 3 system clocks.
   task automatic clk_edge();
      counter_clock = 1'b1;
      repeat (4) @(posedge clock);
      counter_clock = 1'b0;
      repeat (4) @(posedge clock);
   endtask

   logic [7:0] rd;
   logic       exp_m2 [0:8] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};

   initial begin
      n_vec             = 0;
      n_miss            = 0;
      reset             = 1'b1;
      internal_data_bus = 8'h00;
      write_control     = 1'b0;
      write_counter     = 1'b0;
      read_counter      = 1'b0;
      counter_clock     = 1'b0;
      counter_gate      = 1'b1;
      repeat (3) @(posedge clock);
      check_value("reset_out", {15'd0, counter_out}, 16'h0000);
      check_value("reset_rdata", {8'd0, read_data}, 16'h0000);
      reset = 1'b0;
      repeat (3) @(posedge clock);

      // Mode 0, RW=11, count 5: OUT rises on the sixth CLK edge
      cpu_ctrl(8'h30);
      check_value("m0_ctrl_out", {15'd0, counter_out}, 16'h0000);
      cpu_write(8'h05);
      cpu_write(8'h00);
      for (int i = 1; i <= 5; i++) clk_edge();
      check_value("m0_out_edge5", {15'd0, counter_out}, 16'h0000);
      clk_edge();
      check_value("m0_out_edge6", {15'd0, counter_out}, 16'h0001);
      check_value("m0_cnt_edge6", {8'd0, read_data}, 16'h0000);
      clk_edge();
      check_value("m0_out_edge7", {15'd0, counter_out}, 16'h0001);
      check_value("m0_wrap_edge7", {8'd0, read_data}, 16'h00FF);

      // Mode 0, initial 0000h means 65536
      cpu_ctrl(8'h30);
      cpu_write(8'h00);
      cpu_write(8'h00);
      clk_edge();
      check_value("m0_zero_load_out", {15'd0, counter_out}, 16'h0000);
      clk_edge();
      cpu_read(rd);
      check_value("m0_zero_lsb", {8'd0, rd}, 16'h00FF);
      cpu_read(rd);
      check_value("m0_zero_msb", {8'd0, rd}, 16'h00FF);
      check_value("m0_zero_out", {15'd0, counter_out}, 16'h0000);

      // RW=10 loads and reads the MSB only
      cpu_ctrl(8'h20);
      cpu_write(8'h02);
      clk_edge();
      cpu_read(rd);
      check_value("rw10_load", {8'd0, rd}, 16'h0002);
      clk_edge();
      cpu_read(rd);
      check_value("rw10_dec", {8'd0, rd}, 16'h0001);

      // Mode 2, RW=01, count 4: OUT low one period in four
      cpu_ctrl(8'h14);
      check_value("m2_ctrl_out", {15'd0, counter_out}, 16'h0001);
      cpu_write(8'h04);
      for (int i = 0; i < 9; i++) begin
         clk_edge();
         check_value($sformatf("m2_out_edge%0d", i + 1), {15'd0, counter_out}, {15'd0, exp_m2[i]});
      end
      check_value("m2_reload_cnt", {8'd0, read_data}, 16'h0004);
      clk_edge();
      clk_edge();
      clk_edge();
      check_value("m2_cnt1_out", {15'd0, counter_out}, 16'h0000);
      // Gate low while OUT is low forces OUT high and freezes the count
      counter_gate = 1'b0;
      repeat (4) @(posedge clock);
      check_value("m2_gate_low_out", {15'd0, counter_out}, 16'h0001);
      clk_edge();
      check_value("m2_gate_frozen", {8'd0, read_data}, 16'h0001);
      check_value("m2_gate_low_out2", {15'd0, counter_out}, 16'h0001);
      counter_gate = 1'b1;
      repeat (4) @(posedge clock);
      clk_edge();
      check_value("m2_after_gate", {8'd0, read_data}, 16'h0004);
      clk_edge();
      check_value("m2_dec3", {8'd0, read_data}, 16'h0003);
      // Gate rising edge forces a reload on the next event
      counter_gate = 1'b0;
      repeat (4) @(posedge clock);
      counter_gate = 1'b1;
      repeat (4) @(posedge clock);
      clk_edge();
      check_value("m2_gate_rise_reload", {8'd0, read_data}, 16'h0004);

      // Control write coinciding with a count event
      cpu_ctrl(8'h30);
      cpu_write(8'h10);
      cpu_write(8'h00);
      clk_edge();
      clk_edge();
      check_value("coinc_pre_cnt", {8'd0, read_data}, 16'h000F);
      counter_clock = 1'b1;
      repeat (2) @(posedge clock);
      internal_data_bus = 8'h14;
      write_control     = 1'b1;
      @(posedge clock);
      write_control     = 1'b0;
      repeat (5) @(posedge clock);
      counter_clock = 1'b0;
      repeat (4) @(posedge clock);
      check_value("coinc_out", {15'd0, counter_out}, 16'h0001);
      check_value("coinc_cnt", {8'd0, read_data}, 16'h000F);

      // Latch: 1234h, latch, 3 edges, read 34h, 12h, then live LSB
      cpu_ctrl(8'h30);
      cpu_write(8'h34);
      cpu_write(8'h12);
      clk_edge();
      cpu_ctrl(8'h00);
      for (int i = 0; i < 3; i++) clk_edge();
      cpu_read(rd);
      check_value("latch_lsb", {8'd0, rd}, 16'h0034);
      cpu_ctrl(8'h00);
      cpu_read(rd);
      check_value("latch_msb", {8'd0, rd}, 16'h0012);
      cpu_read(rd);
      check_value("latch_live_lsb", {8'd0, rd}, 16'h0031);

      // Reset mid-count in mode 2
      cpu_ctrl(8'h14);
      cpu_write(8'h03);
      clk_edge();
      clk_edge();
      check_value("rst_pre_cnt", {8'd0, read_data}, 16'h0002);
      reset = 1'b1;
      @(posedge clock);
      #1;
      check_value("rst_mid_out", {15'd0, counter_out}, 16'h0000);
      check_value("rst_mid_rdata", {8'd0, read_data}, 16'h0000);
      @(posedge clock);
      reset = 1'b0;
      @(posedge clock);
      clk_edge();
      clk_edge();
      check_value("rst_after_out", {15'd0, counter_out}, 16'h0000);
      check_value("rst_after_rdata", {8'd0, read_data}, 16'h0000);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule
`default_nettype wire
